tron_round_ctrl: RTL and testbench

//  Round/match sequencer for the two-player light-cycle game. Sits between the start switch,
//  the collision detector and the snake/trail datapath. Clears the arena, runs a countdown,

---
 rtl/tron_pkg.sv | 31 +++
 rtl/tron_tick_div.sv | 39 +++
 rtl/tron_round_ctrl.sv | 178 +++++++++++++++++
 tb/tb_tron_round_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/tron_pkg.sv
// Shared types for the light-cycle game: round states, winner codes, step directions.
// Also provides the saturating score increment used by the round controller.
package tron_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StInit,
        StCountdown,
        StRun,
        StCrash,
        StMatchOver
    } round_state_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    // Direction encoding shared with the keyboard input block
    typedef enum logic [1:0] {
        DirUp,
        DirRight,
        DirDown,
        DirLeft
    } step_dir_t;

    function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic [3:0] lim);
        return (v >= lim) ? lim : v + 4'd1;
    endfunction

endpackage

// File: rtl/tron_tick_div.sv
// Game-tick divider: counts 0..DIV-1 while enabled and pulses tick_o on the last count.
// A synchronous clear (or disable) parks the count at zero.
module tron_tick_div #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count_q, count_d;

    assign tick_o = en_i && (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (clr_i || !en_i) begin
            count_d = '0;
        end else if (count_q == LAST) begin
            count_d = '0;
        end else begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/tron_round_ctrl.sv
// Round/match sequencer for the two-player light-cycle game: arena clear, countdown,
// move-step pulses, crash scoring and match winner. All outputs are registered.
module tron_round_ctrl
    import tron_pkg::*;
#(
    parameter int unsigned TICK_DIV        = 1777778,
    parameter int unsigned CLEAR_CYCLES    = 128,
    parameter int unsigned COUNTDOWN_TICKS = 3,
    parameter int unsigned CRASH_TICKS     = 2,
    parameter int unsigned WIN_SCORE       = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       crash1,
    input  logic       crash2,
    output logic       clear_trails,
    output logic [6:0] clear_idx,
    output logic       step,
    output logic [1:0] countdown,
    output logic       round_active,
    output logic       game_over,
    output logic [1:0] winner,
    output logic [3:0] score1,
    output logic [3:0] score2
);

    localparam logic [6:0] IDX_LAST = 7'(CLEAR_CYCLES - 1);
    localparam logic [1:0] CD_LOAD  = 2'(COUNTDOWN_TICKS);
    localparam int unsigned CTW     = $clog2(CRASH_TICKS + 1);
    localparam logic [CTW-1:0] CT_LAST = CTW'(CRASH_TICKS - 1);
    localparam logic [3:0] WIN      = 4'(WIN_SCORE);

    round_state_t   state_q, state_d;
    logic [6:0]     clear_idx_q, clear_idx_d;
    logic [1:0]     countdown_q, countdown_d;
    logic [CTW-1:0] crash_ticks_q, crash_ticks_d;
    logic [3:0]     score1_q, score1_d, score2_q, score2_d;
    logic [1:0]     winner_q, winner_d;
    logic           step_q, step_d;
    logic           clear_trails_q, clear_trails_d;
    logic           round_active_q, round_active_d;
    logic           game_over_q, game_over_d;
    logic           tick, div_en, state_chg;

    assign div_en = (state_q == StCountdown) || (state_q == StRun) || (state_q == StCrash);

    tron_tick_div #(
        .DIV (TICK_DIV)
    ) u_tick_div (
        .clk    (clk),
        .reset  (reset),
        .en_i   (div_en),
        .clr_i  (state_chg),
        .tick_o (tick)
    );

    always_comb begin
        state_d  = state_q;
        score1_d = score1_q;
        score2_d = score2_q;
        winner_d = winner_q;
        step_d   = 1'b0;

        if (!start) begin
            state_d  = StIdle;
            score1_d = 4'd0;
            score2_d = 4'd0;
            winner_d = WIN_NONE;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d  = StInit;
                    score1_d = 4'd0;
                    score2_d = 4'd0;
                    winner_d = WIN_NONE;
                end
                StInit: begin
                    if (clear_idx_q == IDX_LAST) state_d = StCountdown;
                end
                StCountdown: begin
                    if (tick && (countdown_q == 2'd1)) state_d = StRun;
                end
                StRun: begin
                    // A crash pre-empts a coincident tick, so no step is issued
                    if (crash1 || crash2) begin
                        state_d = StCrash;
                        if (crash1 && crash2) begin
                            winner_d = WIN_DRAW;
                        end else if (crash2) begin
                            winner_d = WIN_P1;
                            score1_d = sat_inc(score1_q, WIN);
                        end else begin
                            winner_d = WIN_P2;
                            score2_d = sat_inc(score2_q, WIN);
                        end
                    end else if (tick) begin
                        step_d = 1'b1;
                    end
                end
                StCrash: begin
                    if (tick && (crash_ticks_q == CT_LAST)) begin
                        state_d = ((score1_q == WIN) || (score2_q == WIN)) ? StMatchOver : StInit;
                    end
                end
                StMatchOver: begin
                    state_d = StMatchOver;
                end
                default: state_d = StIdle;
            endcase
        end

        state_chg = (state_d != state_q);

        if (state_d == StInit && state_chg) winner_d = WIN_NONE;

        clear_idx_d = (state_d == StInit && !state_chg) ? clear_idx_q + 7'd1 : 7'd0;

        countdown_d = 2'd0;
        if (state_d == StCountdown) begin
            if (state_chg) begin
                countdown_d = CD_LOAD;
            end else if (tick) begin
                countdown_d = countdown_q - 2'd1;
            end else begin
                countdown_d = countdown_q;
            end
        end

        crash_ticks_d = '0;
        if (state_d == StCrash && !state_chg) begin
            crash_ticks_d = tick ? crash_ticks_q + 1'b1 : crash_ticks_q;
        end

        clear_trails_d = (state_d == StInit);
        round_active_d = (state_d == StRun);
        game_over_d    = (state_d == StMatchOver);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StIdle;
            clear_idx_q    <= 7'd0;
            countdown_q    <= 2'd0;
            crash_ticks_q  <= '0;
            score1_q       <= 4'd0;
            score2_q       <= 4'd0;
            winner_q       <= WIN_NONE;
            step_q         <= 1'b0;
            clear_trails_q <= 1'b0;
            round_active_q <= 1'b0;
            game_over_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            clear_idx_q    <= clear_idx_d;
            countdown_q    <= countdown_d;
            crash_ticks_q  <= crash_ticks_d;
            score1_q       <= score1_d;
            score2_q       <= score2_d;
            winner_q       <= winner_d;
            step_q         <= step_d;
            clear_trails_q <= clear_trails_d;
            round_active_q <= round_active_d;
            game_over_q    <= game_over_d;
        end
    end

    assign clear_trails = clear_trails_q;
    assign clear_idx    = clear_idx_q;
    assign step         = step_q;
    assign countdown    = countdown_q;
    assign round_active = round_active_q;
    assign game_over    = game_over_q;
    assign winner       = winner_q;
    assign score1       = score1_q;
    assign score2       = score2_q;

endmodule

// File: tb/tb_tron_round_ctrl.sv
// Randomized bench for tron_round_ctrl: a phase/elapsed-time model predicts every output
// each cycle; matches are run to completion, aborted by start=0, or cut by reset.
module tb_tron_round_ctrl;

    localparam int TD  = 4;
    localparam int CLR = 8;
    localparam int CDT = 3;
    localparam int CRT = 2;
    localparam int WS  = 3;

    localparam int PH_IDLE  = 0;
    localparam int PH_INIT  = 1;
    localparam int PH_CD    = 2;
    localparam int PH_RUN   = 3;
    localparam int PH_CRASH = 4;
    localparam int PH_OVER  = 5;

    logic       clk = 1'b0;
    logic       reset, start, crash1, crash2;
    logic       clear_trails, step, round_active, game_over;
    logic [6:0] clear_idx;
    logic [1:0] countdown, winner;
    logic [3:0] score1, score2;

    always #5 clk = ~clk;

    tron_round_ctrl #(
        .TICK_DIV        (TD),
        .CLEAR_CYCLES    (CLR),
        .COUNTDOWN_TICKS (CDT),
        .CRASH_TICKS     (CRT),
        .WIN_SCORE       (WS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .crash1       (crash1),
        .crash2       (crash2),
        .clear_trails (clear_trails),
        .clear_idx    (clear_idx),
        .step         (step),
        .countdown    (countdown),
        .round_active (round_active),
        .game_over    (game_over),
        .winner       (winner),
        .score1       (score1),
        .score2       (score2)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model: current phase, cycles spent in it, scores, last result, step pulse
    int m_ph = PH_IDLE;
    int m_t = 0;
    int m_s1 = 0;
    int m_s2 = 0;
    int m_w = 0;
    int m_step = 0;
    int crash_d = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_step();
        int nstep;
        nstep = 0;
        if (reset || !start) begin
            m_ph = PH_IDLE; m_t = 0; m_s1 = 0; m_s2 = 0; m_w = 0;
        end else begin
            case (m_ph)
                PH_IDLE: begin
                    m_ph = PH_INIT; m_t = 0; m_s1 = 0; m_s2 = 0; m_w = 0;
                end
                PH_INIT: begin
                    if (m_t == CLR - 1) begin m_ph = PH_CD; m_t = 0; end
                    else m_t++;
                end
                PH_CD: begin
                    if (m_t == CDT * TD - 1) begin m_ph = PH_RUN; m_t = 0; end
                    else m_t++;
                end
                PH_RUN: begin
                    if (crash1 || crash2) begin
                        if (crash1 && crash2) m_w = 3;
                        else if (crash2) begin m_w = 1; m_s1 = min_i(m_s1 + 1, WS); end
                        else begin m_w = 2; m_s2 = min_i(m_s2 + 1, WS); end
                        m_ph = PH_CRASH; m_t = 0;
                    end else begin
                        if (m_t % TD == TD - 1) nstep = 1;
                        m_t++;
                    end
                end
                PH_CRASH: begin
                    if (m_t == CRT * TD - 1) begin
                        if (m_s1 == WS || m_s2 == WS) m_ph = PH_OVER;
                        else begin m_ph = PH_INIT; m_w = 0; end
                        m_t = 0;
                    end else begin
                        m_t++;
                    end
                end
                default: ;
            endcase
        end
        m_step = nstep;
    endtask

    task automatic compare_all();
        check("clear_trails", 32'(clear_trails), 32'(m_ph == PH_INIT));
        check("clear_idx", 32'(clear_idx), (m_ph == PH_INIT) ? m_t : 0);
        check("countdown", 32'(countdown), (m_ph == PH_CD) ? (CDT - m_t / TD) : 0);
        check("round_active", 32'(round_active), 32'(m_ph == PH_RUN));
        check("game_over", 32'(game_over), 32'(m_ph == PH_OVER));
        check("step", 32'(step), m_step);
        check("winner", 32'(winner), m_w);
        check("score1", 32'(score1), m_s1);
        check("score2", 32'(score2), m_s2);
    endtask

    task automatic tick_cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        int mode;
        int abort_at;
        int over_cnt;
        int post;
        logic done;
        logic [1:0] pat;

        reset = 1'b1; start = 1'b0; crash1 = 1'b0; crash2 = 1'b0;
        repeat (3) tick_cycle();

        for (int m = 0; m < 8; m++) begin
            mode = m % 4;
            abort_at = $urandom_range(20, 200);
            over_cnt = 0;
            post = 0;
            done = 1'b0;
            reset = 1'b0;
            start = 1'b1;
            for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
                if (m_ph == PH_RUN) begin
                    if (m_t == 0) crash_d = $urandom_range(0, 14);
                    if (m_t == crash_d) begin
                        pat = (m == 0) ? 2'b10 : 2'($urandom_range(1, 3));
                        crash1 = pat[0];
                        crash2 = pat[1];
                    end else begin
                        crash1 = 1'b0;
                        crash2 = 1'b0;
                    end
                end else begin
                    // Crash inputs outside RUN must be ignored
                    crash1 = 1'($urandom_range(0, 1));
                    crash2 = 1'($urandom_range(0, 1));
                end
                if (mode == 1 && cyc >= abort_at && m_ph == PH_CD) start = 1'b0;
                if (mode == 2 && cyc >= abort_at && m_ph == PH_RUN) reset = 1'b1;
                if (!start || reset) post++;
                if (m_ph == PH_OVER) over_cnt++;
                tick_cycle();
                if (over_cnt >= 6 || post >= 2) done = 1'b1;
            end
            check("match_end", 32'(done), 32'd1);
            reset = 1'b0;
            start = 1'b0;
            crash1 = 1'b0;
            crash2 = 1'b0;
            repeat (3) tick_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
